ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
Execute stage of the 32-bit 5-stage pipeline. It is the consumer end of the ID/EX register interface.
- Receives decoded control, register operands and the sign-extended immediate.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Computes the ALU result and registers everything into the EX/MEM pipeline register.
- Hosts an iterative multiplier that stalls the front of the pipe while it runs.

Parameters:
WIDTH, 32, datapath width in bits
MUL_STEPS, 32, shift-add iterations per multiply (equals WIDTH)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
Ex  input  4  from ID/EX: [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc
MemR  input  1  from ID/EX: load
MemW  input  1  from ID/EX: store
Wb  input  2  from ID/EX: [1]=RegWrite, [0]=MemtoReg
RegRs  input  5  from ID/EX: rs index
RegRt  input  5  from ID/EX: rt index
RegRd  input  5  from ID/EX: rd index
Exsign_extend  input  32  from ID/EX: immediate; [5:0] is the funct field
data1  input  32  from ID/EX: rs value
data2  input  32  from ID/EX: rt value
mem_wb_regwrite  input  1  MEM/WB RegWrite
mem_wb_rd  input  5  MEM/WB destination register
mem_wb_data  input  32  MEM/WB writeback data
ex_stall  output  1  combinational; freeze PC, IF/ID and ID/EX
ex_mem_alu  output  32  EX/MEM ALU result or address
ex_mem_wdata  output  32  EX/MEM store data (forwarded rt)
ex_mem_rd  output  5  EX/MEM destination register
ex_mem_memr  output  1  EX/MEM load
ex_mem_memw  output  1  EX/MEM store
ex_mem_wb  output  2  EX/MEM {RegWrite, MemtoReg}

Behaviour:
- Reset (synchronous, active-high; clock and reset named clk and rst as elsewhere in the codebase):
  - All ex_mem_* outputs clear to 0.
  - FSM goes to IDLE, step counter to 0, ex_stall=0.
  - Reset asserted mid-multiply aborts the operation; no result is written.
- Forwarding applies to rs and rt independently:
  - EX/MEM source is used when ex_mem_wb[1]=1, ex_mem_rd!=0 and ex_mem_rd matches the operand index; it has priority.
  - Otherwise MEM/WB source (mem_wb_data) is used when mem_wb_regwrite=1, mem_wb_rd!=0 and mem_wb_rd matches.
  - Otherwise data1 / data2 is used.
  - Loads are never forwarded from EX/MEM; the ID hazard detector guarantees a bubble before any load-use.
- ALU operand B = Exsign_extend when ALUSrc=1, else forwarded rt.
- ALUOp decode:
  - 00: add.
  - 01: sub.
  - 11: slt against the immediate (result 1 or 0, signed).
  - 10: by funct — 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed), 0x18 mul (low 32 bits of the product to rd). Any other funct gives result 0 and RegWrite is still honoured.
- Arithmetic wraps modulo 2^32; no overflow trap.
- Destination: ex_mem_rd = RegRd when RegDst=1, else RegRt.
- Non-mul instructions: one-cycle latency; EX/MEM captures on every edge while ex_stall=0.
- Multiply FSM (mul = ALUOp 10 and funct 0x18):
  - IDLE:
    - If mul is present: latch the forwarded operands, ex_stall=1, EX/MEM loads a bubble (all controls 0), go to RUN with count=0.
    - Otherwise normal flow.
  - RUN:
    - One shift-add step per cycle, ex_stall=1, EX/MEM loads a bubble.
    - When count reaches MUL_STEPS-1, go to DONE.
  - DONE: ex_stall=0; EX/MEM captures the product with the mul's controls and rd; go to IDLE.
  - A mul occupies EX for MUL_STEPS+2 cycles.
  - Back-to-back muls restart from IDLE with no extra gap.
  - Operands are latched in IDLE, so changes on the forwarding sources during the stall are ignored.
- A bubble arriving on the ID/EX inputs (all controls 0) passes through as a bubble.

Optional Feature:
EX_MUL_EN
- Defined: multiplier and FSM are present as described above.
- Undefined:
  - Funct 0x18 is treated as an unknown funct (result 0).
  - ex_stall is tied to 0.
  - No FSM or multiplier logic is synthesised.

Decomposition:
- Shared package holds:
  - ALUOp encodings and the funct constants (ADD, SUB, AND, OR, SLT, MUL).
  - Ex/Wb bit-position constants.
  - FSM state encoding (IDLE, RUN, DONE).
- Natural sub-module: ex_forward_unit. It is purely combinational; inputs are the indices and write-enables, outputs are 2-bit selects for A and B.

Test Plan:
1. Forwarding from EX/MEM: add r3=5+7, then sub r4=r3-r1 with r1=2 -> second result 10, fetched via EX/MEM.
2. Forwarding priority: EX/MEM and MEM/WB both target r3 (values 9 and 4) -> operand 9. Same case with rd=0 -> data1 is used.
3. ALUSrc and store: sw with base r2=0x100, imm=-4, r5=0xAB forwarded -> ex_mem_alu=0xFC, ex_mem_wdata=0xAB, ex_mem_memw=1.
4. Multiply: mul 0xFFFF x 0x10001 -> ex_stall high for exactly 33 cycles; bubbles in EX/MEM during the stall; then ex_mem_alu=0xFFFFFFFF and rd correct.
5. Reset during multiply: assert rst at RUN count 10 -> next edge ex_stall=0, ex_mem_*=0, FSM IDLE.
6. Signed slt: -1 slt 1 gives 1; 1 slt -1 gives 0; unknown funct 0x3F gives result 0 with RegWrite preserved.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALUOp/funct codes, ID/EX control
// bit positions, forwarding selects and multiplier FSM states.
package ex_stage_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_SLTI  = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;
    localparam logic [5:0] FUNCT_MUL = 6'h18;

    localparam int EX_REGDST   = 3;
    localparam int EX_ALUOP_HI = 2;
    localparam int EX_ALUOP_LO = 1;
    localparam int EX_ALUSRC   = 0;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam logic [1:0] FWD_REG    = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/ex_stage_forward_unit.sv
// Combinational RAW forwarding select for the rs and rt operands of EX.
// EX/MEM has priority over MEM/WB; register 0 is never forwarded.
module ex_forward_unit
    import ex_stage_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       ex_mem_regwrite,
    input  logic [4:0] ex_mem_rd,
    input  logic       mem_wb_regwrite,
    input  logic [4:0] mem_wb_rd,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    logic ex_mem_ok;
    logic mem_wb_ok;

    always_comb begin
        ex_mem_ok = ex_mem_regwrite && (ex_mem_rd != 5'd0);
        mem_wb_ok = mem_wb_regwrite && (mem_wb_rd != 5'd0);

        fwd_a = FWD_REG;
        if (ex_mem_ok && (ex_mem_rd == rs))      fwd_a = FWD_EX_MEM;
        else if (mem_wb_ok && (mem_wb_rd == rs)) fwd_a = FWD_MEM_WB;

        fwd_b = FWD_REG;
        if (ex_mem_ok && (ex_mem_rd == rt))      fwd_b = FWD_EX_MEM;
        else if (mem_wb_ok && (mem_wb_rd == rt)) fwd_b = FWD_MEM_WB;
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU and the EX/MEM pipeline register.
// Define EX_MUL_EN to include the iterative shift-add multiplier and its stall FSM.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       Ex,
    input  logic             MemR,
    input  logic             MemW,
    input  logic [1:0]       Wb,
    input  logic [4:0]       RegRs,
    input  logic [4:0]       RegRt,
    input  logic [4:0]       RegRd,
    input  logic [WIDTH-1:0] Exsign_extend,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             mem_wb_regwrite,
    input  logic [4:0]       mem_wb_rd,
    input  logic [WIDTH-1:0] mem_wb_data,
    output logic             ex_stall,
    output logic [WIDTH-1:0] ex_mem_alu,
    output logic [WIDTH-1:0] ex_mem_wdata,
    output logic [4:0]       ex_mem_rd,
    output logic             ex_mem_memr,
    output logic             ex_mem_memw,
    output logic [1:0]       ex_mem_wb
);

    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic [WIDTH-1:0] op_a, fwd_rt, op_b, alu_res;
    logic [4:0]       dest_rd;
    alu_op_e          alu_op;
    logic [5:0]       funct;

    logic             mul_stall, mul_done;
    logic [WIDTH-1:0] mul_prod;
    logic [4:0]       mul_rd;
    logic [1:0]       mul_wb;

    logic [WIDTH-1:0] alu_d, alu_q, wdata_d, wdata_q;
    logic [4:0]       rd_d, rd_q;
    logic             memr_d, memr_q, memw_d, memw_q;
    logic [1:0]       wb_d, wb_q;

    ex_forward_unit u_fwd (
        .rs              (RegRs),
        .rt              (RegRt),
        .ex_mem_regwrite (wb_q[WB_REGWRITE]),
        .ex_mem_rd       (rd_q),
        .mem_wb_regwrite (mem_wb_regwrite),
        .mem_wb_rd       (mem_wb_rd),
        .fwd_a           (fwd_a_sel),
        .fwd_b           (fwd_b_sel)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        case (fwd_a_sel)
            FWD_EX_MEM: op_a = alu_q;
            FWD_MEM_WB: op_a = mem_wb_data;
            default:    op_a = data1;
        endcase
        case (fwd_b_sel)
            FWD_EX_MEM: fwd_rt = alu_q;
            FWD_MEM_WB: fwd_rt = mem_wb_data;
            default:    fwd_rt = data2;
        endcase
        op_b    = Ex[EX_ALUSRC] ? Exsign_extend : fwd_rt;
        alu_op  = alu_op_e'(Ex[EX_ALUOP_HI:EX_ALUOP_LO]);
        funct   = Exsign_extend[5:0];
        dest_rd = Ex[EX_REGDST] ? RegRd : RegRt;
    end

    // Funct 0x18 lands in the default arm here; the multiplier supplies its result.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALUOP_ADD:  alu_res = op_a + op_b;
            ALUOP_SUB:  alu_res = op_a - op_b;
            ALUOP_SLTI: alu_res = WIDTH'($signed(op_a) < $signed(Exsign_extend));
            default: begin
                case (funct)
                    FUNCT_ADD: alu_res = op_a + op_b;
                    FUNCT_SUB: alu_res = op_a - op_b;
                    FUNCT_AND: alu_res = op_a & op_b;
                    FUNCT_OR:  alu_res = op_a | op_b;
                    FUNCT_SLT: alu_res = WIDTH'($signed(op_a) < $signed(op_b));
                    default:   alu_res = '0;
                endcase
            end
        endcase
    end

`ifdef EX_MUL_EN
    localparam int CNT_W = $clog2(MUL_STEPS);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
    logic [4:0]       mrd_q, mrd_d;
    logic [1:0]       mwb_q, mwb_d;
    logic             is_mul;

    always_comb begin
        is_mul    = (alu_op == ALUOP_FUNCT) && (funct == FUNCT_MUL);
        state_d   = state_q;
        count_d   = count_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        mrd_d     = mrd_q;
        mwb_d     = mwb_q;
        mul_stall = 1'b0;
        mul_done  = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (is_mul) begin
                    mcand_d   = op_a;
                    mplier_d  = fwd_rt;
                    prod_d    = '0;
                    mrd_d     = dest_rd;
                    mwb_d     = Wb;
                    count_d   = '0;
                    mul_stall = 1'b1;
                    state_d   = MUL_RUN;
                end
            end
            MUL_RUN: begin
                mul_stall = 1'b1;
                if (mplier_q[0]) prod_d = prod_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 1'b1;
                if (count_q == CNT_W'(MUL_STEPS - 1)) state_d = MUL_DONE;
            end
            MUL_DONE: begin
                mul_done = 1'b1;
                state_d  = MUL_IDLE;
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUL_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: multiplier datapath needs no reset; the FSM gates every use of it.
    always_ff @(posedge clk) begin
        mcand_q  <= mcand_d;
        mplier_q <= mplier_d;
        prod_q   <= prod_d;
        mrd_q    <= mrd_d;
        mwb_q    <= mwb_d;
    end

    assign mul_prod = prod_q;
    assign mul_rd   = mrd_q;
    assign mul_wb   = mwb_q;
`else
    assign mul_stall = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_prod  = '0;
    assign mul_rd    = '0;
    assign mul_wb    = '0;
`endif

    always_comb begin
        alu_d   = alu_res;
        wdata_d = fwd_rt;
        rd_d    = dest_rd;
        memr_d  = MemR;
        memw_d  = MemW;
        wb_d    = Wb;
        if (mul_done) begin
            alu_d  = mul_prod;
            rd_d   = mul_rd;
            memr_d = 1'b0;
            memw_d = 1'b0;
            wb_d   = mul_wb;
        end else if (mul_stall) begin
            alu_d   = '0;
            wdata_d = '0;
            rd_d    = '0;
            memr_d  = 1'b0;
            memw_d  = 1'b0;
            wb_d    = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q   <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            memr_q  <= 1'b0;
            memw_q  <= 1'b0;
            wb_q    <= '0;
        end else begin
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            memr_q  <= memr_d;
            memw_q  <= memw_d;
            wb_q    <= wb_d;
        end
    end

    assign ex_stall     = mul_stall && !rst;
    assign ex_mem_alu   = alu_q;
    assign ex_mem_wdata = wdata_q;
    assign ex_mem_rd    = rd_q;
    assign ex_mem_memr  = memr_q;
    assign ex_mem_memw  = memw_q;
    assign ex_mem_wb    = wb_q;

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed instructions push expected EX/MEM
// contents; a negedge monitor pops and compares each non-bubble result.
module tb_ex_stage;

    localparam logic [3:0] EX_R    = 4'b1100;
    localparam logic [3:0] EX_MEM  = 4'b0001;
    localparam logic [3:0] EX_SLTI = 4'b0111;
    localparam logic [3:0] EX_SUB  = 4'b0010;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  Ex;
    logic        MemR, MemW;
    logic [1:0]  Wb;
    logic [4:0]  RegRs, RegRt, RegRd;
    logic [31:0] Exsign_extend, data1, data2;
    logic        mem_wb_regwrite;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_data;
    logic        ex_stall;
    logic [31:0] ex_mem_alu, ex_mem_wdata;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_memr, ex_mem_memw;
    logic [1:0]  ex_mem_wb;

    ex_stage dut (
        .clk(clk), .rst(rst), .Ex(Ex), .MemR(MemR), .MemW(MemW), .Wb(Wb),
        .RegRs(RegRs), .RegRt(RegRt), .RegRd(RegRd), .Exsign_extend(Exsign_extend),
        .data1(data1), .data2(data2), .mem_wb_regwrite(mem_wb_regwrite),
        .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data), .ex_stall(ex_stall),
        .ex_mem_alu(ex_mem_alu), .ex_mem_wdata(ex_mem_wdata), .ex_mem_rd(ex_mem_rd),
        .ex_mem_memr(ex_mem_memr), .ex_mem_memw(ex_mem_memw), .ex_mem_wb(ex_mem_wb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        memr;
        logic        memw;
        logic [1:0]  wb;
    } exp_t;

    exp_t sb_q[$];
    exp_t got, want;
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic [31:0] alu, input logic [31:0] wdata,
                                input logic [4:0] rd, input logic memr, input logic memw,
                                input logic [1:0] wb);
        exp_t e;
        e.alu = alu; e.wdata = wdata; e.rd = rd; e.memr = memr; e.memw = memw; e.wb = wb;
        return e;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] ex, input logic mr, input logic mw, input logic [1:0] wb,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] imm, input logic [31:0] d1, input logic [31:0] d2);
        Ex = ex; MemR = mr; MemW = mw; Wb = wb;
        RegRs = rs; RegRt = rt; RegRd = rd;
        Exsign_extend = imm; data1 = d1; data2 = d2;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        mem_wb_regwrite = we; mem_wb_rd = rd; mem_wb_data = d;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic rtype(input logic [5:0] funct, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] alu_exp, input logic [31:0] wdata_exp);
        drive(EX_R, 1'b0, 1'b0, 2'b10, rs, rt, rd, {26'h0, funct}, d1, d2);
        sb_q.push_back(mk(alu_exp, wdata_exp, rd, 1'b0, 1'b0, 2'b10));
        step();
    endtask

`ifdef EX_MUL_EN
    task automatic run_mul(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [31:0] d1, input logic [31:0] d2, input bit disturb,
                           output int stall_cycles, output bit bubbles_ok);
        drive(EX_R, 1'b0, 1'b0, 2'b10, rs, rt, rd, 32'h18, d1, d2);
        stall_cycles = 0;
        bubbles_ok   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ex_stall) break;
            stall_cycles++;
            if (stall_cycles > 1 && (ex_mem_wb != 2'b00 || ex_mem_memr || ex_mem_memw))
                bubbles_ok = 1'b0;
            if (disturb && stall_cycles == 2) mem_wb_data = 32'h63;
            @(posedge clk);
        end
        step();
    endtask
`endif

    // Monitor: any non-bubble EX/MEM content must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && (ex_mem_wb != 2'b00 || ex_mem_memr || ex_mem_memw)) begin
                got = mk(ex_mem_alu, ex_mem_wdata, ex_mem_rd, ex_mem_memr, ex_mem_memw, ex_mem_wb);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h want none", got);
                end else begin
                    want = sb_q.pop_front();
                    check($sformatf("ex_mem_rd%0d", want.rd), 96'(got), 96'(want));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        int  sc;
        bit  bok;
        rst = 1'b1;
        set_wb(1'b0, 5'd0, 32'h0);
        drive(EX_R, 1'b1, 1'b1, 2'b11, 5'd1, 5'd2, 5'd3, 32'h20, 32'h11, 32'h22);
        step();
        step();
        check("reset_state", {63'h0, ex_stall, ex_mem_alu, ex_mem_wdata, ex_mem_rd,
                              ex_mem_memr, ex_mem_memw, ex_mem_wb}, 96'h0);
        drive(4'b0000, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        rst = 1'b0;
        step();

        // EX/MEM forwarding
        rtype(6'h20, 5'd5, 5'd6, 5'd3, 32'd5, 32'd7, 32'd12, 32'd7);
        rtype(6'h22, 5'd3, 5'd1, 5'd4, 32'hDEAD, 32'd2, 32'd10, 32'd2);

        // priority, MEM/WB-only, and rd=0 exclusion
        rtype(6'h20, 5'd10, 5'd11, 5'd3, 32'd4, 32'd5, 32'd9, 32'd5);
        set_wb(1'b1, 5'd3, 32'd4);
        rtype(6'h20, 5'd3, 5'd0, 5'd7, 32'd100, 32'd0, 32'd9, 32'd0);
        rtype(6'h20, 5'd3, 5'd12, 5'd8, 32'd100, 32'd1, 32'd5, 32'd1);
        set_wb(1'b1, 5'd0, 32'd4);
        rtype(6'h20, 5'd10, 5'd11, 5'd0, 32'd4, 32'd5, 32'd9, 32'd5);
        rtype(6'h20, 5'd0, 5'd13, 5'd9, 32'd100, 32'd1, 32'd101, 32'd1);

        // store with forwarded data, then load
        set_wb(1'b1, 5'd5, 32'hAB);
        drive(EX_MEM, 1'b0, 1'b1, 2'b00, 5'd2, 5'd5, 5'd0, 32'hFFFF_FFFC, 32'h100, 32'h0);
        sb_q.push_back(mk(32'hFC, 32'hAB, 5'd5, 1'b0, 1'b1, 2'b00));
        step();
        set_wb(1'b0, 5'd0, 32'h0);
        drive(EX_MEM, 1'b1, 1'b0, 2'b11, 5'd2, 5'd8, 5'd0, 32'h8, 32'h200, 32'h55);
        sb_q.push_back(mk(32'h208, 32'h55, 5'd8, 1'b1, 1'b0, 2'b11));
        step();

        // signed slt, slti, logic ops, unknown funct, ALUOp sub
        rtype(6'h2A, 5'd14, 5'd15, 5'd10, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd1);
        rtype(6'h2A, 5'd16, 5'd17, 5'd11, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
        drive(EX_SLTI, 1'b0, 1'b0, 2'b10, 5'd18, 5'd19, 5'd0, 32'd3, 32'hFFFF_FFFB, 32'd0);
        sb_q.push_back(mk(32'd1, 32'd0, 5'd19, 1'b0, 1'b0, 2'b10));
        step();
        rtype(6'h24, 5'd20, 5'd21, 5'd12, 32'hF0F0, 32'hFF00, 32'hF000, 32'hFF00);
        rtype(6'h25, 5'd22, 5'd23, 5'd13, 32'hF0F0, 32'hFF00, 32'hFFF0, 32'hFF00);
        rtype(6'h3F, 5'd24, 5'd25, 5'd14, 32'd3, 32'd4, 32'd0, 32'd4);
        drive(EX_SUB, 1'b0, 1'b0, 2'b10, 5'd26, 5'd27, 5'd0, 32'h0, 32'd10, 32'd3);
        sb_q.push_back(mk(32'd7, 32'd3, 5'd27, 1'b0, 1'b0, 2'b10));
        step();

        // incoming bubble stays a bubble
        drive(4'b0000, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 32'd5, 32'd6);
        step();
        check("bubble_ctrl", {92'h0, ex_mem_memr, ex_mem_memw, ex_mem_wb}, 96'h0);

`ifdef EX_MUL_EN
        sb_q.push_back(mk(32'hFFFF_FFFF, 32'h1_0001, 5'd15, 1'b0, 1'b0, 2'b10));
        run_mul(5'd28, 5'd29, 5'd15, 32'hFFFF, 32'h1_0001, 1'b0, sc, bok);
        check("mul1_stall_cycles", 96'(sc), 96'd33);
        check("mul1_bubbles", 96'(bok), 96'd1);

        set_wb(1'b1, 5'd30, 32'd7);
        sb_q.push_back(mk(32'd42, 32'd6, 5'd16, 1'b0, 1'b0, 2'b10));
        run_mul(5'd30, 5'd31, 5'd16, 32'd0, 32'd6, 1'b1, sc, bok);
        check("mul2_stall_cycles", 96'(sc), 96'd33);
        check("mul2_bubbles", 96'(bok), 96'd1);
        set_wb(1'b0, 5'd0, 32'h0);

        drive(EX_R, 1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 5'd17, 32'h18, 32'd3, 32'd4);
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        check("rst_mid_mul", {63'h0, ex_stall, ex_mem_alu, ex_mem_wdata, ex_mem_rd,
                              ex_mem_memr, ex_mem_memw, ex_mem_wb}, 96'h0);
        drive(4'b0000, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        rst = 1'b0;
        step();
        check("idle_after_rst", 96'(ex_stall), 96'd0);
`else
        drive(EX_R, 1'b0, 1'b0, 2'b10, 5'd28, 5'd29, 5'd15, 32'h18, 32'hFFFF, 32'h1_0001);
        sb_q.push_back(mk(32'd0, 32'h1_0001, 5'd15, 1'b0, 1'b0, 2'b10));
        #1;
        check("mul_disabled_stall", 96'(ex_stall), 96'd0);
        step();
`endif

        rtype(6'h20, 5'd3, 5'd4, 5'd5, 32'd1, 32'd2, 32'd3, 32'd2);
        drive(4'b0000, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        repeat (3) step();
        check("scoreboard_drained", 96'(sb_q.size()), 96'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
